// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver with valid/ready byte output.
// Define UART_RX_PARITY_EN to build the 8E1 variant with an even-parity check.
module uart_rx #(
  parameter logic [31:0] CLK_FREQ = 32'd50_000_000,
  parameter logic [31:0] BAUDRATE = 32'd115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_i,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int BAUD_CNT_MAX  = int'(CLK_FREQ / BAUDRATE);
  localparam int BAUD_CNT_HALF = BAUD_CNT_MAX / 2;
  localparam int CNT_W         = $clog2(BAUD_CNT_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_e;

  logic             rx_sync1_q;
  logic             rx_sync2_q;
  logic             rx_prev_q;
  state_e           state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             fall_edge;
  logic             baud_last;

  assign fall_edge = rx_prev_q & ~rx_sync2_q;
  assign baud_last = (baud_cnt_q == CNT_LAST);

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= uart_rx_i;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q;
  logic parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
      baud_cnt_q <= baud_cnt_q + CNT_ONE;

      case (state_q)
        ST_IDLE: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (fall_edge) begin
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_cnt_q == CNT_MID) begin
            baud_cnt_q <= '0;
            state_q    <= rx_sync2_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            shift_q    <= {rx_sync2_q, shift_q[7:1]};
            baud_cnt_q <= '0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_last) begin
            parity_bad_q <= rx_sync2_q ^ (^shift_q);
            baud_cnt_q   <= '0;
            state_q      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_last) begin
            baud_cnt_q <= '0;
            if (!rx_sync2_q) begin
              // A low stop bit may be a break; wait for the line to recover.
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
            end else if (parity_bad_q) begin
              parity_err_q <= 1'b1;
              state_q      <= ST_IDLE;
`endif
            end else begin
              if (!rx_valid_q || rx_ready_i) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          baud_cnt_q <= '0;
          if (rx_sync2_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          baud_cnt_q <= '0;
          bit_cnt_q  <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - Self-checking bench for uart_rx against a frame-level reference.
// Honours UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_line = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  int frame_err_cnt = 0;
  int overrun_cnt = 0;
  int parity_err_cnt = 0;
  int valid_cycles = 0;

  uart_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_i   (uart_line),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .parity_err_o(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) valid_cycles++;
    if (frame_err) frame_err_cnt++;
    if (overrun) overrun_cnt++;
    if (parity_err) parity_err_cnt++;
  end

  task automatic clear_mon();
    got_q.delete();
    frame_err_cnt = 0;
    overrun_cnt = 0;
    parity_err_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic send_bit(input logic b);
    uart_line = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    uart_line = 1'b1;
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the stop level is left on the line afterwards.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    uart_line = 1'b1;
    rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err});
    end
  endtask

  task automatic test_single();
    logic [7:0] first;
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
    n_checks++;
    if (first !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", first); end
    n_checks++;
    if (valid_cycles !== 1) begin n_fail++; $display("FAIL single_valid_pulse: got %0d cycles expected 1", valid_cycles); end
    n_checks++;
    if (frame_err_cnt + overrun_cnt + parity_err_cnt !== 0) begin
      n_fail++; $display("FAIL single_errors: got %0d expected 0", frame_err_cnt + overrun_cnt + parity_err_cnt);
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [7:0] first;
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle_bits(1);
    n_checks++;
    if (overrun_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", overrun_cnt); end
    n_checks++;
    if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid_held: got %b expected 1", rx_valid); end
    n_checks++;
    if (rx_data !== 8'hA3) begin n_fail++; $display("FAIL overrun_data_held: got %h expected a3", rx_data); end
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL overrun_drain_count: got %0d expected 1", got_q.size()); end
    n_checks++;
    if (first !== 8'hA3) begin n_fail++; $display("FAIL overrun_drain_data: got %h expected a3", first); end
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drained_valid: got %b expected 0", rx_valid); end
  endtask

  task automatic test_frame_error();
    logic [7:0] first;
    rx_ready = 1'b1;
    clear_mon();
    send_frame(8'h81, 1'b0);
    repeat (20 * BIT) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL frame_err_no_byte: got %0d bytes expected 0", got_q.size()); end
    idle_bits(1);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++;
    if (frame_err_cnt !== 1) begin n_fail++; $display("FAIL frame_err_pulses: got %0d expected 1", frame_err_cnt); end
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL frame_err_recover_count: got %0d expected 1", got_q.size()); end
    n_checks++;
    if (first !== 8'h3C) begin n_fail++; $display("FAIL frame_err_recover_data: got %h expected 3c", first); end
  endtask

  task automatic test_glitch();
    clear_mon();
    uart_line = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    uart_line = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    n_checks++;
    if (got_q.size() !== 0 || rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_no_byte: got %0d bytes valid %b expected 0 and 0", got_q.size(), rx_valid);
    end
    n_checks++;
    if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL glitch_data_kept: got %h expected 3c", rx_data); end
    n_checks++;
    if (frame_err_cnt + overrun_cnt + parity_err_cnt !== 0) begin
      n_fail++; $display("FAIL glitch_errors: got %0d expected 0", frame_err_cnt + overrun_cnt + parity_err_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] first;
    rx_ready = 1'b1;
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    uart_line = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL midreset_values: got valid %b data %h expected 0 and 00", rx_valid, rx_data);
    end
    idle_bits(5);
    send_frame(8'h12, 1'b1);
    idle_bits(1);
    first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++;
    if (got_q.size() !== 1) begin n_fail++; $display("FAIL midreset_count: got %0d expected 1", got_q.size()); end
    n_checks++;
    if (first !== 8'h12) begin n_fail++; $display("FAIL midreset_data: got %h expected 12", first); end
    n_checks++;
    if (frame_err_cnt + overrun_cnt + parity_err_cnt !== 0) begin
      n_fail++; $display("FAIL midreset_errors: got %0d expected 0", frame_err_cnt + overrun_cnt + parity_err_cnt);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    rx_ready = 1'b1;
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      idle_bits($urandom_range(0, 1));
    end
    idle_bits(1);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= got_q.size()) begin
        n_fail++; $display("FAIL random_byte%0d: got none expected %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (frame_err_cnt + overrun_cnt + parity_err_cnt !== 0) begin
      n_fail++; $display("FAIL random_errors: got %0d expected 0", frame_err_cnt + overrun_cnt + parity_err_cnt);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask

  task automatic test_parity();
    logic [7:0] first;
    rx_ready = 1'b1;
    clear_mon();
    send_frame_par(8'h07, 1'b0);
    idle_bits(1);
    n_checks++;
    if (parity_err_cnt !== 1) begin n_fail++; $display("FAIL parity_err_pulses: got %0d expected 1", parity_err_cnt); end
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL parity_err_no_byte: got %0d expected 0", got_q.size()); end
    send_frame_par(8'h07, 1'b1);
    idle_bits(1);
    first = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_checks++;
    if (got_q.size() !== 1 || first !== 8'h07) begin
      n_fail++; $display("FAIL parity_ok_data: got %0d bytes first %h expected 1 byte 07", got_q.size(), first);
    end
    n_checks++;
    if (parity_err_cnt !== 1) begin n_fail++; $display("FAIL parity_ok_no_err: got %0d expected 1", parity_err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back_overrun();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    test_random_stream();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
